// File: rtl/uart_seq_pkg.sv
// Shared types for the UART block sequencer.
// UART_SEQ_CHECKSUM_EN adds a trailing XOR byte per block.
package uart_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } seq_state_t;

    localparam int BYTE_CNT_W = 4;

`ifdef UART_SEQ_CHECKSUM_EN
    localparam int BYTES_PER_BLOCK = 9;

    function automatic logic [7:0] xor_bytes(
        input logic [63:0] w
    );
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            x = x ^ w[i*8 +: 8];
        end
        return x;
    endfunction
`else
    localparam int BYTES_PER_BLOCK = 8;
`endif

endpackage

// File: rtl/seq_block_fifo.sv
// Block buffer between the RX assembler and the sequencer.
// Pushes while full are dropped here; the caller flags them.
module seq_block_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

endmodule

// File: rtl/uart_block_sequencer.sv
// Buffers RX blocks, runs each through the core, serialises results to TX.
// UART_SEQ_CHECKSUM_EN appends an XOR checksum byte to every block.
module uart_block_sequencer
    import uart_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [63:0]              in_data,
    output logic                     core_start,
    output logic [63:0]              core_data,
    input  logic                     core_done,
    input  logic [63:0]              core_result,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     timeout_err,
    output logic [1:0]               seq_state
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    seq_state_t            state_q, state_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [63:0]           shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  tx_en_d, core_start_d, timeout_d;
    logic [7:0]            tx_data_d;
    logic [63:0]           core_data_d;
    logic                  overflow_q;
    logic                  pop;
    logic [63:0]           head;
    logic                  fifo_full;
    logic                  fifo_empty;
`ifdef UART_SEQ_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    seq_block_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        tx_en_d      = 1'b0;
        tx_data_d    = tx_data;
        core_start_d = 1'b0;
        core_data_d  = core_data;
        timeout_d    = 1'b0;
        pop          = 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                core_start_d = 1'b1;
                core_data_d  = head;
                pop          = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    shift_d    = core_result;
                    byte_cnt_d = '0;
`ifdef UART_SEQ_CHECKSUM_EN
                    csum_d     = xor_bytes(core_result);
`endif
                    state_d    = SEND;
                end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND: begin
                // tx_en high now means a byte went out last cycle
                if (!tx_busy && !tx_en) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = shift_q[63:56];
`ifdef UART_SEQ_CHECKSUM_EN
                    if (byte_cnt_q == BYTE_CNT_W'(8)) tx_data_d = csum_q;
`endif
                    shift_d    = {shift_q[55:0], 8'h00};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == BYTE_CNT_W'(BYTES_PER_BLOCK - 1))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            core_start  <= 1'b0;
            core_data   <= '0;
            timeout_err <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef UART_SEQ_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_en       <= tx_en_d;
            tx_data     <= tx_data_d;
            core_start  <= core_start_d;
            core_data   <= core_data_d;
            timeout_err <= timeout_d;
            overflow_q  <= overflow_q | (in_valid & fifo_full);
`ifdef UART_SEQ_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign overflow  = overflow_q;
    assign seq_state = state_q;

endmodule
